// File: rtl/zkr_seed_source.sv
// Zkr seed CSR producer: raw-bit health tests (RCT, optional APT), 16-bit packing, entropy FIFO.
// Define ZKR_APT_EN to build the adaptive proportion test; otherwise only the RCT gates entropy.
module zkr_seed_source #(
  parameter int DEPTH      = 4,
  parameter int BIST_BITS  = 256,
  parameter int RCT_CUTOFF = 32,
  parameter int APT_LO     = 16,
  parameter int APT_HI     = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RawValidI,
  input  logic        RawBitI,
  input  logic        SeedReadM,
  output logic [31:0] SeedValM,
  output logic        EntFailM
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(BIST_BITS + 1);
  localparam int RW = $clog2(RCT_CUTOFF + 1);

  typedef enum logic [1:0] {
    ST_BIST = 2'b00,
    ST_WAIT = 2'b01,
    ST_ES16 = 2'b10,
    ST_DEAD = 2'b11
  } opst_e;

  opst_e          state_q, state_d;
  logic [BW-1:0]  bist_q, bist_d;
  logic [RW-1:0]  run_q, run_d;
  logic           last_q, last_d;
  logic [15:0]    acc_q, acc_d;
  logic [3:0]     nacc_q, nacc_d;
  logic [15:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           fail_q;
  logic           consume, rct_fail, apt_fail, fail;
  logic           word_done, push, pop;

  // A raw bit is taken on any cycle RawValidI=1 (no backpressure); SeedReadM is a
  // one-cycle strobe that consumes the head only while OPST is ES16.
  always_comb begin
    consume  = RawValidI && (state_q != ST_DEAD);
    run_d    = run_q;
    last_d   = last_q;
    rct_fail = 1'b0;
    if (consume) begin
      last_d = RawBitI;
      if ((run_q != '0) && (RawBitI == last_q)) run_d = run_q + RW'(1);
      else                                      run_d = RW'(1);
      rct_fail = (run_d == RW'(RCT_CUTOFF));
    end
  end

`ifdef ZKR_APT_EN
  logic [6:0] win_q, win_d, ones_q, ones_d, ones_inc;

  always_comb begin
    win_d    = win_q;
    ones_d   = ones_q;
    apt_fail = 1'b0;
    ones_inc = ones_q + {6'b0, RawBitI};
    if (consume) begin
      if (win_q == 7'd63) begin
        win_d    = '0;
        ones_d   = '0;
        apt_fail = (int'(ones_inc) < APT_LO) || (int'(ones_inc) > APT_HI);
      end else begin
        win_d  = win_q + 7'd1;
        ones_d = ones_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q  <= '0;
      ones_q <= '0;
    end else begin
      win_q  <= win_d;
      ones_q <= ones_d;
    end
  end
`else
  assign apt_fail = 1'b0;
`endif

  assign fail = rct_fail || apt_fail;

  always_comb begin
    state_d   = state_q;
    bist_d    = bist_q;
    acc_d     = acc_q;
    nacc_d    = nacc_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;
    if (fail) begin
      // RCT outranks APT when both trip on the same bit.
      state_d = rct_fail ? ST_DEAD : ST_BIST;
      if (!rct_fail) bist_d = '0;
      acc_d  = '0;
      nacc_d = '0;
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
    end else begin
      if (consume && (state_q == ST_BIST)) begin
        bist_d = bist_q + BW'(1);
        if (bist_d == BW'(BIST_BITS)) state_d = ST_WAIT;
      end
      if (consume && ((state_q == ST_WAIT) || (state_q == ST_ES16))) begin
        acc_d = {acc_q[14:0], RawBitI};
        if (nacc_q == 4'd15) begin
          word_done = 1'b1;
          nacc_d    = '0;
        end else begin
          nacc_d = nacc_q + 4'd1;
        end
      end
      pop  = SeedReadM && (state_q == ST_ES16);
      push = word_done && ((cnt_q != CW'(DEPTH)) || pop);
      if (pop)  rd_d = rd_q + AW'(1);
      if (push) wr_d = wr_q + AW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      if ((state_q == ST_WAIT) || (state_q == ST_ES16))
        state_d = (cnt_d != '0) ? ST_ES16 : ST_WAIT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BIST;
      bist_q  <= '0;
      run_q   <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      nacc_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bist_q  <= bist_d;
      run_q   <= run_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      nacc_q  <= nacc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail;
    end
  end

  // Storage needs no reset: entries are only visible once counted as occupied.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= acc_d;
  end

  assign SeedValM = (state_q == ST_ES16) ? {2'b10, 14'b0, mem_q[rd_q]} : {state_q, 30'b0};
  assign EntFailM = fail_q;
endmodule
